// File: rtl/sram_burst_port_ctrl_if.sv
// Command, read/write stream and SRAM pin bundle for sram_burst_port_ctrl.
// cmd_mask exists only when SRAM_HALF_MASK_EN is defined.
interface sram_burst_port_ctrl_if #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 14
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef SRAM_HALF_MASK_EN
  logic [1:0]            cmd_mask;
`endif
  logic [BITS-1:0]       rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [BITS-1:0]       wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  done;
  logic                  CEN;
  logic [1:0]            WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [BITS-1:0]       D;
  logic [BITS-1:0]       Q;

  // Client side: issues commands, sinks read data, sources write data, models the SRAM.
  modport master (
`ifdef SRAM_HALF_MASK_EN
    output cmd_mask,
`endif
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output rd_ready, wr_data, wr_valid, Q,
    input  cmd_ready, rd_data, rd_valid, wr_ready, done,
    input  CEN, WEN, A, D
  );

  modport slave (
`ifdef SRAM_HALF_MASK_EN
    input  cmd_mask,
`endif
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  rd_ready, wr_data, wr_valid, Q,
    output cmd_ready, rd_data, rd_valid, wr_ready, done,
    output CEN, WEN, A, D
  );
endinterface

// File: rtl/sram_burst_port_ctrl.sv
// Burst master turning a (addr, len, direction) command into SRAM pin cycles with valid/ready data streams.
// Define SRAM_HALF_MASK_EN to latch a per-burst half-word write mask from cmd_mask.
module sram_burst_port_ctrl #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 14
) (
  input logic                   CLK,
  input logic                   RST_N,
  sram_burst_port_ctrl_if.slave bus
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, a_hold;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [BITS-1:0]       d_hold;
  logic [BITS-1:0]       fifo [2];
  logic                  wr_ptr, rd_ptr, inflight;
  logic [1:0]            count, slots_after_pop;
  logic [1:0]            wr_mask;
  logic                  accept, rd_issue, wr_issue, issue, push, pop;

`ifdef SRAM_HALF_MASK_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_mask <= 2'b00;
    end else if (accept) begin
      wr_mask <= bus.cmd_mask;
    end
  end
`else
  assign wr_mask = 2'b00;
`endif

  assign accept = (state == IDLE) && bus.cmd_valid;
  assign push   = inflight;
  assign pop    = (count != 2'd0) && bus.rd_ready;
  assign issue  = rd_issue || wr_issue;

  // Counting this cycle's pop as a freed slot keeps reads streaming at one word per cycle.
  assign slots_after_pop = count + {1'b0, inflight} - {1'b0, pop};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.done      = 1'b0;
    rd_issue      = 1'b0;
    wr_issue      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            state_nxt = FIN;
          end else if (bus.cmd_write) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        rd_issue = (remaining != '0) && (slots_after_pop < 2'd2);
        if ((remaining == '0) && !inflight && (count == 2'd0)) begin
          state_nxt = FIN;
        end
      end
      WR: begin
        bus.wr_ready = (remaining != '0);
        wr_issue     = bus.wr_valid && (remaining != '0);
        // Leave straight after the last word so done follows the final issue directly.
        if ((remaining == '0) || (wr_issue && (remaining == LEN_WIDTH'(1)))) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rd_valid = (count != 2'd0);
  assign bus.rd_data  = fifo[rd_ptr];
  assign bus.CEN      = !issue;
  assign bus.WEN      = wr_issue ? wr_mask : 2'b11;
  assign bus.A        = issue ? addr : a_hold;
  assign bus.D        = wr_issue ? bus.wr_data : d_hold;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      a_hold    <= '0;
      d_hold    <= '0;
    end else begin
      if (accept) begin
        addr      <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
      inflight <= rd_issue;
      if (push) begin
        fifo[wr_ptr] <= bus.Q;
        wr_ptr       <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      count  <= count + {1'b0, push} - {1'b0, pop};
      a_hold <= bus.A;
      d_hold <= bus.D;
    end
  end

  cmd_len_in_range: assert property (@(posedge CLK) disable iff (!RST_N)
    (bus.cmd_valid && bus.cmd_ready) |-> (bus.cmd_len <= MAX_LEN));

endmodule

// File: tb/tb_sram_burst_port_ctrl.sv
// Scoreboard bench for sram_burst_port_ctrl: behavioural SRAM, reference memory, decoupled monitor.
// Build with SRAM_HALF_MASK_EN defined to also exercise the half-word mask path.
module tb_sram_burst_port_ctrl;
  localparam int BITS  = 64;
  localparam int AW    = 13;
  localparam int LW    = 14;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0]   a;
    logic [1:0]      wen;
    logic [BITS-1:0] d;
    bit              is_write;
  } pin_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sram_burst_port_ctrl_if #(.BITS(BITS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  sram_burst_port_ctrl #(.BITS(BITS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  pin_t            pin_q[$];
  logic [BITS-1:0] rd_q[$];
  logic [BITS-1:0] wq[$];
  logic [BITS-1:0] cur_words[$];
  logic [BITS-1:0] ref_mem [DEPTH];
  logic [BITS-1:0] sram    [DEPTH];
  logic [BITS-1:0] last_rd_data = '0;
  int issue_cyc[$];
  int pop_cyc[$];
  int total = 0, bad = 0;
  int cyc = 0, hs_cyc = 0, idle_cyc = 0, done_cyc = -1;
  int pending_done = 0, done_count = 0, rd_issued = 0, rd_popped = 0;
  int stall_from = 0, stall_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural single-cycle-latency SRAM with active-low half-word write enables.
  always @(posedge CLK) begin
    if (!bus.CEN) begin
      if (!bus.WEN[0]) sram[bus.A][31:0]  <= bus.D[31:0];
      if (!bus.WEN[1]) sram[bus.A][63:32] <= bus.D[63:32];
      bus.Q <= sram[bus.A];
    end
  end

  always @(negedge CLK) begin
    if (bus.done === 1'b1) done_count++;
    if (RST_N) begin
      if (bus.CEN === 1'b0) begin
        issue_cyc.push_back(cyc);
        checkOutput("issue_expected", 64'(pin_q.size() != 0), 64'd1);
        if (pin_q.size() != 0) begin
          pin_t e;
          e = pin_q.pop_front();
          checkOutput("pin_A", 64'(bus.A), 64'(e.a));
          checkOutput("pin_WEN", 64'(bus.WEN), 64'(e.wen));
          if (e.is_write) checkOutput("pin_D", bus.D, e.d);
          else rd_issued++;
        end
      end
      if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
        rd_popped++;
        pop_cyc.push_back(cyc);
        last_rd_data = bus.rd_data;
        checkOutput("read_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) checkOutput("rd_data", bus.rd_data, rd_q.pop_front());
      end
      if (bus.CEN === 1'b0 && bus.WEN === 2'b11) begin
        checkOutput("outstanding_le2", 64'((rd_issued - rd_popped) <= 2), 64'd1);
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        checkOutput("done_expected", 64'(pending_done > 0), 64'd1);
        if (pending_done > 0) pending_done--;
      end
    end
  end

  // Pushes the expected pin cycles, read data and done pulse, then performs the handshake.
  task automatic issueCmd(input bit wr, input logic [AW-1:0] addr, input int len, input logic [1:0] mask);
    int guard;
    logic [AW-1:0]   a;
    logic [BITS-1:0] w;
    pin_t e;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    checkOutput("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    issue_cyc.delete();
    pop_cyc.delete();
    cur_words.delete();
    done_cyc = -1;
    for (int i = 0; i < len; i++) begin
      a = AW'((int'(addr) + i) % DEPTH);
      if (wr) begin
        w = (wq.size() > 0) ? wq.pop_front() : {$urandom, $urandom};
        cur_words.push_back(w);
        e.a = a; e.wen = mask; e.d = w; e.is_write = 1'b1;
        if (!mask[0]) ref_mem[a][31:0]  = w[31:0];
        if (!mask[1]) ref_mem[a][63:32] = w[63:32];
      end else begin
        e.a = a; e.wen = 2'b11; e.d = '0; e.is_write = 1'b0;
        rd_q.push_back(ref_mem[a]);
      end
      pin_q.push_back(e);
    end
    pending_done++;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LW'(len);
`ifdef SRAM_HALF_MASK_EN
    bus.cmd_mask  = mask;
`endif
    bus.cmd_valid = 1'b1;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input int len,
                               input logic [1:0] mask, input bit hold);
    int  k, guard;
    bit  fire, idle;
    issueCmd(wr, addr, len, mask);
    k = 0; guard = 0; idle = 1'b0;
    while (!idle && guard < 2000) begin
      if (wr) begin
        bus.wr_valid = (k < len) && (hold || ($urandom_range(0, 1) == 1));
        bus.wr_data  = (k < len) ? cur_words[k] : {$urandom, $urandom};
      end else begin
        bus.rd_ready = hold ? !(guard >= stall_from && guard < stall_from + stall_cnt)
                            : ($urandom_range(0, 1) == 1);
      end
      @(negedge CLK);
      fire = (bus.wr_valid === 1'b1) && (bus.wr_ready === 1'b1);
      idle = (bus.cmd_ready === 1'b1);
      if (idle) idle_cyc = cyc;
      @(posedge CLK); #1;
      if (fire) k++;
      guard++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    checkOutput("burst_returns_idle", 64'(idle), 64'd1);
    if (wr) checkOutput("write_words_taken", 64'(k), 64'(len));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  guard;
    bit  seen;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
`ifdef SRAM_HALF_MASK_EN
    bus.cmd_mask  = 2'b00;
`endif
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_wr_ready", 64'(bus.wr_ready), 64'd0);
    checkOutput("reset_CEN", 64'(bus.CEN), 64'd1);
    checkOutput("reset_WEN", 64'(bus.WEN), 64'd3);
    checkOutput("reset_A", 64'(bus.A), 64'd0);
    checkOutput("reset_D", bus.D, 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] write burst addr=5 len=4");
    wq = '{64'h11, 64'h22, 64'h33, 64'h44};
    applyStimulus(1'b1, AW'(5), 4, 2'b00, 1'b1);
    checkOutput("wr_issue_count", 64'(issue_cyc.size()), 64'd4);
    if (issue_cyc.size() == 4) begin
      checkOutput("wr_first_issue_cycle", 64'(issue_cyc[0] - hs_cyc), 64'd0);
      checkOutput("wr_last_issue_cycle", 64'(issue_cyc[3] - hs_cyc), 64'd3);
      checkOutput("wr_done_after_last", 64'(done_cyc - issue_cyc[3]), 64'd1);
    end
    checkOutput("wr_ready_after_done", 64'(idle_cyc - done_cyc), 64'd1);

    $display("[TB] read burst addr=5 len=4");
    applyStimulus(1'b0, AW'(5), 4, 2'b00, 1'b1);
    checkOutput("rd_pop_count", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4) begin
      checkOutput("rd_first_data_cycle", 64'(pop_cyc[0] - hs_cyc), 64'd2);
      checkOutput("rd_last_data_cycle", 64'(pop_cyc[3] - hs_cyc), 64'd5);
      checkOutput("rd_done_after_pop", 64'(done_cyc > pop_cyc[3]), 64'd1);
    end

    $display("[TB] stalled read len=6");
    applyStimulus(1'b1, AW'(200), 6, 2'b00, 1'b0);
    stall_from = 2;
    stall_cnt  = 5;
    applyStimulus(1'b0, AW'(200), 6, 2'b00, 1'b1);
    stall_from = 0;
    stall_cnt  = 0;
    checkOutput("stall_pop_count", 64'(pop_cyc.size()), 64'd6);

    $display("[TB] wrapping write and readback");
    applyStimulus(1'b1, AW'(DEPTH - 2), 4, 2'b00, 1'b1);
    applyStimulus(1'b0, AW'(DEPTH - 2), 4, 2'b00, 1'b0);

    $display("[TB] zero-length command");
    applyStimulus(1'b0, AW'(50), 0, 2'b00, 1'b1);
    checkOutput("len0_no_issue", 64'(issue_cyc.size()), 64'd0);
    checkOutput("len0_done_cycle", 64'(done_cyc - hs_cyc), 64'd0);
    checkOutput("len0_idle_cycle", 64'(idle_cyc - hs_cyc), 64'd1);

    $display("[TB] reset in the middle of a read");
    issueCmd(1'b0, AW'(200), 6, 2'b00);
    bus.rd_ready = 1'b0;
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 20) begin
      @(negedge CLK);
      seen = (bus.rd_valid === 1'b1);
      guard++;
    end
    checkOutput("rst_word_buffered", 64'(seen), 64'd1);
    #1;
    RST_N = 1'b0;
    pin_q.delete();
    rd_q.delete();
    pending_done = 0;
    rd_issued    = 0;
    rd_popped    = 0;
    done_count   = 0;
    @(negedge CLK);
    checkOutput("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("rst_CEN", 64'(bus.CEN), 64'd1);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    checkOutput("rst_no_done_pulse", 64'(done_count), 64'd0);

`ifdef SRAM_HALF_MASK_EN
    $display("[TB] half-word masked write");
    wq = '{64'hAAAA_AAAA_BBBB_BBBB};
    applyStimulus(1'b1, AW'(100), 1, 2'b01, 1'b1);
    applyStimulus(1'b0, AW'(100), 1, 2'b00, 1'b1);
    checkOutput("mask_readback", last_rd_data, 64'hAAAA_AAAA_0000_0000);
`endif

    $display("[TB] randomized commands");
    for (int n = 0; n < 24; n++) begin
      bit            w, hold;
      logic [AW-1:0] ad;
      int            ln;
      logic [1:0]    m;
      w    = ($urandom_range(0, 1) == 1);
      hold = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) ad = AW'(DEPTH - 1 - int'($urandom_range(0, 5)));
      else ad = AW'($urandom_range(0, 300));
      ln = int'($urandom_range(0, 10));
      m  = 2'b00;
`ifdef SRAM_HALF_MASK_EN
      if (w) m = 2'($urandom_range(0, 3));
`endif
      applyStimulus(w, ad, ln, m, hold);
    end

    repeat (4) @(posedge CLK);
    #1;
    checkOutput("pins_all_seen", 64'(pin_q.size()), 64'd0);
    checkOutput("reads_all_seen", 64'(rd_q.size()), 64'd0);
    checkOutput("dones_all_seen", 64'(pending_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
